// File: rtl/cpu_bus_master_if.sv
// Command/response stream plus cartridge CPU bus pins for the Famicom-side bus master.
// master: the bus master itself; slave: the command source and the cartridge side.
interface cpu_bus_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        m2;
  logic        romsel;
  logic        cpu_rw;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_data_oe;
  logic [7:0]  cpu_data_in;
  logic [31:0] cycle_count;

  modport master (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, cpu_data_in,
    output cmd_ready, rsp_valid, rsp_rdata, m2, romsel, cpu_rw, cpu_addr,
           cpu_data_out, cpu_data_oe, cycle_count
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, cpu_data_in,
    input  cmd_ready, rsp_valid, rsp_rdata, m2, romsel, cpu_rw, cpu_addr,
           cpu_data_out, cpu_data_oe, cycle_count
  );
endinterface

// File: rtl/cpu_bus_master.sv
// Famicom-side CPU bus initiator: turns a valid/ready command stream into continuous
// M2 cycles (idle reads when no command), with every bus output registered.
module cpu_bus_master #(
  parameter int unsigned HALF_CLKS = 3,
  parameter logic [15:0] IDLE_ADDR = 16'h0000
) (
  input  logic             clk,
  input  logic             reset_n,
  cpu_bus_master_if.master bus
);
  localparam logic [8:0] HALF_PH = 9'(HALF_CLKS);
  localparam logic [8:0] LAST_PH = 9'(2 * HALF_CLKS - 1);

  logic [8:0]  ph_q, ph_d;
  logic        rw_q, rw_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        active_q, active_d;
  logic        m2_q, m2_d;
  logic        romsel_q, romsel_d;
  logic        oe_q, oe_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic        wrap;
  logic        accept;

  always_comb begin
    wrap          = (ph_q == LAST_PH);
    accept        = wrap & bus.cmd_valid & cmd_ready_q;
    ph_d          = wrap ? 9'd0 : ph_q + 9'd1;
    rw_d          = rw_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    active_d      = active_q;
    cycle_count_d = cycle_count_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;

    // Cycle boundary: load the accepted command or fall back to an idle read.
    if (wrap) begin
      cycle_count_d = cycle_count_q + 32'd1;
      if (accept) begin
        rw_d     = bus.cmd_rw;
        addr_d   = bus.cmd_addr;
        active_d = 1'b1;
        if (!bus.cmd_rw) wdata_d = bus.cmd_wdata;
      end else begin
        rw_d     = 1'b1;
        addr_d   = IDLE_ADDR;
        active_d = 1'b0;
      end
      // Last m2-high clk: capture read data on the same edge m2 falls.
      if (active_q && rw_q) begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = bus.cpu_data_in;
      end
    end

    // Decode from next-state values so pins move on the same edge as m2.
    m2_d        = (ph_d >= HALF_PH);
    romsel_d    = ~(m2_d & active_d & addr_d[15]);
    oe_d        = m2_d & active_d & ~rw_d;
    cmd_ready_d = (ph_d == LAST_PH);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ph_q          <= 9'd0;
      rw_q          <= 1'b1;
      addr_q        <= IDLE_ADDR;
      wdata_q       <= 8'd0;
      active_q      <= 1'b0;
      m2_q          <= 1'b0;
      romsel_q      <= 1'b1;
      oe_q          <= 1'b0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 8'd0;
      cycle_count_q <= 32'd0;
    end else begin
      ph_q          <= ph_d;
      rw_q          <= rw_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      active_q      <= active_d;
      m2_q          <= m2_d;
      romsel_q      <= romsel_d;
      oe_q          <= oe_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.m2           = m2_q;
  assign bus.romsel       = romsel_q;
  assign bus.cpu_rw       = rw_q;
  assign bus.cpu_addr     = addr_q[14:0];
  assign bus.cpu_data_out = wdata_q;
  assign bus.cpu_data_oe  = oe_q;
  assign bus.cycle_count  = cycle_count_q;
endmodule

// File: doc/cpu_bus_master.md
Name: cpu_bus_master

Overview:
- Famicom-side initiator for the cartridge CPU bus. It turns a valid/ready command stream (read or write, 16-bit address, data) into cycle-accurate M2/ROMSEL/R-W/address/data bus cycles.
- It is the host end that drives the mapper core in the bench-on-FPGA and dumper/programmer builds.
- M2 runs continuously; a cycle with no command is an idle read that does not select ROM.

Parameters:
- HALF_CLKS, 3, clk periods per M2 half-phase; legal range 1..255.
- IDLE_ADDR, 16'h0000, address driven on idle cycles.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  synchronous, active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted this clk when cmd_valid is also high.
- cmd_rw  input  1  1 = read, 0 = write.
- cmd_addr  input  16  CPU address.
- cmd_wdata  input  8  write data.
- rsp_valid  output  1  one-clk pulse, read data valid.
- rsp_rdata  output  8  captured read data.
- m2  output  1  M2 phase clock.
- romsel  output  1  active-low ROMSEL, equal to ~(A15 & m2).
- cpu_rw  output  1  R/W line.
- cpu_addr  output  15  A14..A0.
- cpu_data_out  output  8  write data.
- cpu_data_oe  output  1  data bus drive enable (tristate lives in the top level).
- cpu_data_in  input  8  bus data for reads.
- cycle_count  output  32  count of completed M2 cycles, wraps.

Behaviour:
- All outputs are registered; no combinational path from inputs to outputs.
- Phase counter ph runs 0..2*HALF_CLKS-1, then wraps to 0.
  - ph 0..HALF_CLKS-1: m2 = 0.
  - ph HALF_CLKS..2*HALF_CLKS-1: m2 = 1.
- Register state is the current cycle: rw, addr[15:0], wdata, active flag.
- Command acceptance:
  - cmd_ready = 1 only on the clk where ph == 2*HALF_CLKS-1; 0 otherwise.
  - When cmd_valid & cmd_ready: cmd_rw, cmd_addr and cmd_wdata are loaded and the cycle starting at the next ph 0 is active.
  - Otherwise the next cycle is idle: rw = 1, addr = IDLE_ADDR, active = 0.
- Bus outputs:
  - cpu_rw and cpu_addr change only on the transition to ph 0 and are held for the whole cycle.
  - romsel is 0 only while m2 = 1 and addr[15] = 1 on an active cycle. It changes on the same clk edges as m2.
  - Idle cycles keep romsel = 1 regardless of IDLE_ADDR.
- Write cycles:
  - cpu_data_oe = 1 exactly while m2 = 1; it deasserts on the same edge m2 falls.
  - cpu_data_out is valid from ph 0 to the end of the cycle.
- Read cycles:
  - cpu_data_in is sampled at the clk where ph == 2*HALF_CLKS-1, the last clk with m2 high.
  - rsp_rdata is updated and rsp_valid pulses high for exactly one clk on the following edge, which coincides with the m2 falling edge.
  - Idle and write cycles produce no response.
  - rsp_rdata holds its value until the next read response.
- cycle_count increments on every wrap of ph, idle cycles included; it wraps 2^32-1 to 0.
- Back-to-back throughput: one command per M2 cycle. With cmd_valid held high, every cycle is active.
- Latency: command accepted at clk t; its M2 rising edge is at t+1+HALF_CLKS; its rsp_valid is at t+1+2*HALF_CLKS.
- Reset (reset_n = 0 at a clk edge), mid-cycle included:
  - Aborts the current cycle; no rsp_valid is produced for an aborted read.
  - Reset values: ph = 0, m2 = 0, romsel = 1, cpu_rw = 1, cpu_addr = IDLE_ADDR[14:0], cpu_data_oe = 0, cpu_data_out = 0, cmd_ready = 0, rsp_valid = 0, rsp_rdata = 0, cycle_count = 0, next cycle idle.
  - The first clk after reset deasserts is ph = 0 of an idle cycle.
- HALF_CLKS = 1: ready, sample and m2 toggling all occur on alternate clks; the same rules hold.
- cmd_valid asserted when cmd_ready = 0: ignored; the command must be held until acceptance.

Test Plan:
- HALF_CLKS = 3, reset, no commands → m2 has a 6-clk period (3 low / 3 high), romsel stays 1, cpu_rw stays 1, cycle_count = 10 after 60 clks.
- Read of $8123 with cpu_data_in = 8'hA5 → cpu_addr = 15'h0123, romsel low only during the 3 m2-high clks, one rsp_valid with rsp_rdata = 8'hA5 exactly 7 clks after acceptance.
- Write of 8'h3C to $6000 → cpu_rw = 0 for the full cycle, romsel stays 1, cpu_data_oe high for exactly 3 clks aligned with m2 high, cpu_data_out = 8'h3C, no rsp_valid.
- Four back-to-back reads of $8000..$8003 with cmd_valid held high → four consecutive M2 cycles with no idle between, four rsp_valid pulses 6 clks apart.
- reset_n pulsed low during the m2-high phase of a read → m2 = 0 and romsel = 1 on the next clk, no rsp_valid, bus restarts with an idle cycle.
- HALF_CLKS = 1, alternating write $8000/8'h01 and read $C000 → m2 toggles every clk, data_oe only on write high phases, rsp_valid only for the reads.
